// File: rtl/axi_llc_tag_req_arb.sv
// LLC tag-store request arbiter: issues one BIST request after reset, then merges lookups and flushes.
// Optional perf counters are built when AXI_LLC_TAG_ARB_PERF_EN is defined.

package axi_llc_pkg;

  typedef enum logic [1:0] {
    MODE_BIST   = 2'd0,
    MODE_LOOKUP = 2'd1,
    MODE_FLUSH  = 2'd2
  } tag_mode_e;

endpackage

module axi_llc_tag_req_arb
  import axi_llc_pkg::*;
#(
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned IndexLength      = 8,
  parameter int unsigned TagLength        = 20,
  parameter int unsigned MaxStarve        = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [SetAssociativity-1:0] spm_lock_i,
  input  logic [SetAssociativity-1:0] flushed_i,
  input  logic                        lkp_valid_i,
  output logic                        lkp_ready_o,
  input  logic [IndexLength-1:0]      lkp_index_i,
  input  logic [TagLength-1:0]        lkp_tag_i,
  input  logic                        lkp_dirty_i,
  input  logic                        fl_valid_i,
  output logic                        fl_ready_o,
  input  logic [SetAssociativity-1:0] fl_way_i,
  input  logic [IndexLength-1:0]      fl_index_i,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output tag_mode_e                   req_mode_o,
  output logic [SetAssociativity-1:0] req_ind_o,
  output logic [IndexLength-1:0]      req_index_o,
  output logic [TagLength-1:0]        req_tag_o,
  output logic                        req_dirty_o,
  input  logic                        bist_valid_i,
  input  logic [SetAssociativity-1:0] bist_res_i,
  output logic [SetAssociativity-1:0] bist_res_o,
  output logic                        bist_done_o,
  output logic [31:0]                 perf_lkp_cnt_o,
  output logic [31:0]                 perf_fl_cnt_o
);

  localparam int unsigned StarveW = $clog2(MaxStarve + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MaxStarve);

  typedef enum logic [1:0] {
    BIST_REQ,
    BIST_ISSUE,
    BIST_WAIT,
    RUN
  } state_e;

  typedef struct packed {
    tag_mode_e                   mode;
    logic [SetAssociativity-1:0] ind;
    logic [IndexLength-1:0]      index;
    logic [TagLength-1:0]        tag;
    logic                        dirty;
  } req_t;

  state_e                      state_q;
  logic                        slot_valid_q;
  req_t                        slot_q;
  logic [StarveW-1:0]          starve_q;
  logic [SetAssociativity-1:0] bist_res_q;
  logic                        bist_done_q;

  logic                        slot_free;
  logic                        fl_grant;
  logic                        lkp_grant;
  logic                        lkp_drop;
  logic [SetAssociativity-1:0] lkp_ind;

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    lkp_ind   = ~spm_lock_i & ~flushed_i;
    slot_free = !slot_valid_q || req_ready_i;
    fl_grant  = (state_q == RUN) && slot_free && fl_valid_i &&
                (!lkp_valid_i || (starve_q < StarveMax));
    lkp_grant = (state_q == RUN) && slot_free && lkp_valid_i && !fl_grant;
    lkp_drop  = lkp_grant && (lkp_ind == '0);
  end

  assign lkp_ready_o = lkp_grant;
  assign fl_ready_o  = fl_grant;

  // A waiting lookup forces a grant after MaxStarve consecutive flush wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (lkp_grant || !lkp_valid_i) begin
      starve_q <= '0;
    end else if (fl_grant && (starve_q != StarveMax)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // NOTE: state and the output slot use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BIST_REQ;
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      bist_res_q   <= '0;
      bist_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        BIST_REQ: begin
          slot_valid_q <= 1'b1;
          slot_q       <= '{mode: MODE_BIST, default: '0};
          state_q      <= BIST_ISSUE;
        end
        BIST_ISSUE: begin
          if (req_ready_i) begin
            slot_valid_q <= 1'b0;
            state_q      <= BIST_WAIT;
          end
        end
        BIST_WAIT: begin
          if (bist_valid_i) begin
            bist_res_q  <= bist_res_i;
            bist_done_q <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (fl_grant) begin
            slot_valid_q <= 1'b1;
            slot_q       <= '{mode:  MODE_FLUSH,
                              ind:   fl_way_i,
                              index: fl_index_i,
                              tag:   '0,
                              dirty: 1'b0};
          end else if (lkp_grant && !lkp_drop) begin
            slot_valid_q <= 1'b1;
            slot_q       <= '{mode:  MODE_LOOKUP,
                              ind:   lkp_ind,
                              index: lkp_index_i,
                              tag:   lkp_tag_i,
                              dirty: lkp_dirty_i};
          end else if (req_ready_i) begin
            // Drained with nothing to load, including a dropped lookup.
            slot_valid_q <= 1'b0;
          end
        end
        default: state_q <= BIST_REQ;
      endcase
    end
  end

  assign req_valid_o = slot_valid_q;
  assign req_mode_o  = slot_q.mode;
  assign req_ind_o   = slot_q.ind;
  assign req_index_o = slot_q.index;
  assign req_tag_o   = slot_q.tag;
  assign req_dirty_o = slot_q.dirty;
  assign bist_res_o  = bist_res_q;
  assign bist_done_o = bist_done_q;

`ifdef AXI_LLC_TAG_ARB_PERF_EN
  logic [31:0] perf_lkp_q;
  logic [31:0] perf_fl_q;

  // Dropped lookups still count: they were accepted from the requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_lkp_q <= '0;
      perf_fl_q  <= '0;
    end else begin
      if (lkp_grant && (perf_lkp_q != '1)) perf_lkp_q <= perf_lkp_q + 32'd1;
      if (fl_grant && (perf_fl_q != '1))   perf_fl_q  <= perf_fl_q + 32'd1;
    end
  end

  assign perf_lkp_cnt_o = perf_lkp_q;
  assign perf_fl_cnt_o  = perf_fl_q;
`else
  assign perf_lkp_cnt_o = '0;
  assign perf_fl_cnt_o  = '0;
`endif

`ifndef SYNTHESIS
  a_fl_way_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fl_valid_i && fl_ready_o) |-> $onehot(fl_way_i));

  a_bist_res_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != BIST_WAIT) |=> $stable(bist_res_o));

  a_single_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(lkp_ready_o && fl_ready_o));
`endif

endmodule

// File: tb/tb_axi_llc_tag_req_arb.sv
// Directed bench for axi_llc_tag_req_arb: BIST sequencing, lookup payload, backpressure,
// starvation pattern, dropped lookups and mid-operation reset.

module tb_axi_llc_tag_req_arb;
  import axi_llc_pkg::*;

`ifdef AXI_LLC_TAG_ARB_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [7:0]  spm_lock_i = '0;
  logic [7:0]  flushed_i = '0;
  logic        lkp_valid_i = 1'b0;
  logic        lkp_ready_o;
  logic [7:0]  lkp_index_i = '0;
  logic [19:0] lkp_tag_i = '0;
  logic        lkp_dirty_i = 1'b0;
  logic        fl_valid_i = 1'b0;
  logic        fl_ready_o;
  logic [7:0]  fl_way_i = '0;
  logic [7:0]  fl_index_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b1;
  tag_mode_e   req_mode_o;
  logic [7:0]  req_ind_o;
  logic [7:0]  req_index_o;
  logic [19:0] req_tag_o;
  logic        req_dirty_o;
  logic        bist_valid_i = 1'b0;
  logic [7:0]  bist_res_i = '0;
  logic [7:0]  bist_res_o;
  logic        bist_done_o;
  logic [31:0] perf_lkp_cnt_o;
  logic [31:0] perf_fl_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int bist_hs = 0;

  axi_llc_tag_req_arb #(
    .SetAssociativity(8),
    .IndexLength     (8),
    .TagLength       (20),
    .MaxStarve       (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .spm_lock_i    (spm_lock_i),
    .flushed_i     (flushed_i),
    .lkp_valid_i   (lkp_valid_i),
    .lkp_ready_o   (lkp_ready_o),
    .lkp_index_i   (lkp_index_i),
    .lkp_tag_i     (lkp_tag_i),
    .lkp_dirty_i   (lkp_dirty_i),
    .fl_valid_i    (fl_valid_i),
    .fl_ready_o    (fl_ready_o),
    .fl_way_i      (fl_way_i),
    .fl_index_i    (fl_index_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_mode_o    (req_mode_o),
    .req_ind_o     (req_ind_o),
    .req_index_o   (req_index_o),
    .req_tag_o     (req_tag_o),
    .req_dirty_o   (req_dirty_o),
    .bist_valid_i  (bist_valid_i),
    .bist_res_i    (bist_res_i),
    .bist_res_o    (bist_res_o),
    .bist_done_o   (bist_done_o),
    .perf_lkp_cnt_o(perf_lkp_cnt_o),
    .perf_fl_cnt_o (perf_fl_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Count BIST handshakes on the falling edge, where the next rising edge will see them.
  always @(negedge clk_i) begin
    if (rst_ni && req_valid_o && req_ready_i && (req_mode_o == MODE_BIST)) bist_hs++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit exp_fl;

    // Reset values
    #2 rst_ni = 1'b0;
    tick();
    check("rst_req_valid", 32'(req_valid_o), 32'd0);
    check("rst_mode",      32'(req_mode_o),  32'd0);
    check("rst_ind",       32'(req_ind_o),   32'd0);
    check("rst_lkp_ready", 32'(lkp_ready_o), 32'd0);
    check("rst_fl_ready",  32'(fl_ready_o),  32'd0);
    check("rst_bist_res",  32'(bist_res_o),  32'd0);
    check("rst_bist_done", 32'(bist_done_o), 32'd0);
    check("rst_perf_lkp",  perf_lkp_cnt_o,   32'd0);
    check("rst_perf_fl",   perf_fl_cnt_o,    32'd0);

    // BIST sequencing
    rst_ni      = 1'b1;
    req_ready_i = 1'b1;
    tick();
    check("bist_req_valid", 32'(req_valid_o), 32'd1);
    check("bist_req_mode",  32'(req_mode_o),  32'(MODE_BIST));
    check("bist_req_ind",   32'(req_ind_o),   32'd0);
    tick();
    check("bist_wait_valid", 32'(req_valid_o), 32'd0);
    lkp_valid_i = 1'b1;
    fl_valid_i  = 1'b1;
    fl_way_i    = 8'h01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bist_wait_lkp_ready", 32'(lkp_ready_o), 32'd0);
      check("bist_wait_fl_ready",  32'(fl_ready_o),  32'd0);
      check("bist_wait_valid_low", 32'(req_valid_o), 32'd0);
      tick();
    end
    bist_valid_i = 1'b1;
    bist_res_i   = 8'h04;
    #1;
    check("bist_pulse_lkp_ready", 32'(lkp_ready_o), 32'd0);
    check("bist_pulse_fl_ready",  32'(fl_ready_o),  32'd0);
    check("bist_pulse_done",      32'(bist_done_o), 32'd0);
    tick();
    bist_valid_i = 1'b0;
    bist_res_i   = 8'h00;
    lkp_valid_i  = 1'b0;
    fl_valid_i   = 1'b0;
    check("bist_res",       32'(bist_res_o),  32'h04);
    check("bist_done",      32'(bist_done_o), 32'd1);
    check("bist_hs_count1", 32'(bist_hs),     32'd1);

    // A stray BIST pulse in RUN must be ignored
    bist_valid_i = 1'b1;
    bist_res_i   = 8'hFF;
    tick();
    bist_valid_i = 1'b0;
    tick();
    check("bist_res_hold", 32'(bist_res_o), 32'h04);
    check("idle_valid",    32'(req_valid_o), 32'd0);

    // Lookup indicator: ~8'h03 & ~8'h10 = 8'hEC
    spm_lock_i  = 8'h03;
    flushed_i   = 8'h10;
    lkp_valid_i = 1'b1;
    lkp_index_i = 8'h2A;
    lkp_tag_i   = 20'hABCDE;
    lkp_dirty_i = 1'b1;
    #1;
    check("lkp_ready", 32'(lkp_ready_o), 32'd1);
    check("lkp_fl_ready_low", 32'(fl_ready_o), 32'd0);
    tick();
    lkp_valid_i = 1'b0;
    check("lkp_valid", 32'(req_valid_o), 32'd1);
    check("lkp_mode",  32'(req_mode_o),  32'(MODE_LOOKUP));
    check("lkp_ind",   32'(req_ind_o),   32'hEC);
    check("lkp_index", 32'(req_index_o), 32'h2A);
    check("lkp_tag",   32'(req_tag_o),   32'hABCDE);
    check("lkp_dirty", 32'(req_dirty_o), 32'd1);

    // Backpressure with lookup and flush both pending
    req_ready_i = 1'b0;
    lkp_valid_i = 1'b1;
    lkp_index_i = 8'h11;
    lkp_tag_i   = 20'h11111;
    lkp_dirty_i = 1'b0;
    fl_valid_i  = 1'b1;
    fl_way_i    = 8'h20;
    fl_index_i  = 8'h33;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("bp_lkp_ready", 32'(lkp_ready_o), 32'd0);
      check("bp_fl_ready",  32'(fl_ready_o),  32'd0);
      tick();
      check("bp_valid", 32'(req_valid_o), 32'd1);
      check("bp_ind",   32'(req_ind_o),   32'hEC);
      check("bp_tag",   32'(req_tag_o),   32'hABCDE);
      check("bp_mode",  32'(req_mode_o),  32'(MODE_LOOKUP));
    end

    // Release: one transfer per cycle, grant pattern F,F,F,F,L repeating
    req_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_fl = ((i % 5) != 4);
      #1;
      check("starve_fl_ready",  32'(fl_ready_o),  32'(exp_fl));
      check("starve_lkp_ready", 32'(lkp_ready_o), 32'(!exp_fl));
      tick();
      check("starve_valid", 32'(req_valid_o), 32'd1);
      check("starve_mode",  32'(req_mode_o),
            exp_fl ? 32'(MODE_FLUSH) : 32'(MODE_LOOKUP));
      check("starve_ind",   32'(req_ind_o),   exp_fl ? 32'h20 : 32'hEC);
      check("starve_index", 32'(req_index_o), exp_fl ? 32'h33 : 32'h11);
      check("starve_tag",   32'(req_tag_o),   exp_fl ? 32'h0 : 32'h11111);
    end
    lkp_valid_i = 1'b0;
    fl_valid_i  = 1'b0;
    tick();
    check("drain_valid", 32'(req_valid_o), 32'd0);
    check("perf_fl_after_starve", perf_fl_cnt_o, PerfEn ? 32'd8 : 32'd0);

    // Drop: all ways locked or flushed
    spm_lock_i  = 8'hF0;
    flushed_i   = 8'h0F;
    lkp_valid_i = 1'b1;
    #1;
    check("drop_lkp_ready", 32'(lkp_ready_o), 32'd1);
    tick();
    lkp_valid_i = 1'b0;
    check("drop_valid", 32'(req_valid_o), 32'd0);
    check("drop_perf_lkp", perf_lkp_cnt_o, PerfEn ? 32'd4 : 32'd0);
    tick();
    check("drop_valid_still", 32'(req_valid_o), 32'd0);
    check("drop_lkp_ready_low", 32'(lkp_ready_o), 32'd0);

    // Reset while a flush is stalled in the slot
    spm_lock_i  = 8'h00;
    flushed_i   = 8'h00;
    req_ready_i = 1'b0;
    fl_valid_i  = 1'b1;
    fl_way_i    = 8'h01;
    fl_index_i  = 8'h44;
    #1;
    check("rmid_fl_ready", 32'(fl_ready_o), 32'd1);
    tick();
    fl_valid_i = 1'b0;
    check("rmid_valid", 32'(req_valid_o), 32'd1);
    check("rmid_mode",  32'(req_mode_o),  32'(MODE_FLUSH));
    check("rmid_index", 32'(req_index_o), 32'h44);
    tick();
    check("rmid_hold_index", 32'(req_index_o), 32'h44);
    #2 rst_ni = 1'b0;
    #1;
    check("rmid_rst_valid",     32'(req_valid_o), 32'd0);
    check("rmid_rst_bist_done", 32'(bist_done_o), 32'd0);
    check("rmid_rst_bist_res",  32'(bist_res_o),  32'd0);
    check("rmid_rst_perf_fl",   perf_fl_cnt_o,    32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    check("rmid_bist_valid", 32'(req_valid_o), 32'd1);
    check("rmid_bist_mode",  32'(req_mode_o),  32'(MODE_BIST));
    check("rmid_bist_index", 32'(req_index_o), 32'd0);
    req_ready_i = 1'b1;
    tick();
    check("rmid_bist_taken", 32'(req_valid_o), 32'd0);
    check("bist_hs_count2",  32'(bist_hs),     32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_llc_tag_req_arb.md
Name: axi_llc_tag_req_arb

Overview:
- Request arbiter and sequencer directly upstream of the LLC tag store.
- After reset it issues exactly one BIST request to the tag store, waits for the BIST result, then latches that result.
- After that it merges the lookup-descriptor stream and the config flush stream into single tag-store requests through a registered, stall-safe output stage.
- Flush has priority. Lookups are protected by a starvation counter.

Parameters:
- SetAssociativity, 8, number of ways; width of the way indicator.
- IndexLength, 8, set-index width.
- TagLength, 20, tag width.
- MaxStarve, 4, maximum number of consecutive flush grants while a lookup is waiting (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- spm_lock_i  in  SetAssociativity  ways configured as SPM.
- flushed_i  in  SetAssociativity  ways already flushed.
- lkp_valid_i  in  1  lookup request valid.
- lkp_ready_o  out  1  lookup request accepted.
- lkp_index_i  in  IndexLength  lookup set index.
- lkp_tag_i  in  TagLength  lookup tag.
- lkp_dirty_i  in  1  lookup is a write (set dirty).
- fl_valid_i  in  1  flush request valid.
- fl_ready_o  out  1  flush request accepted.
- fl_way_i  in  SetAssociativity  one-hot way to flush.
- fl_index_i  in  IndexLength  flush set index.
- req_valid_o  out  1  tag-store request valid.
- req_ready_i  in  1  tag store ready.
- req_mode_o  out  axi_llc_pkg mode  Bist, Lookup or Flush.
- req_ind_o  out  SetAssociativity  way indicator.
- req_index_o  out  IndexLength  set index.
- req_tag_o  out  TagLength  tag.
- req_dirty_o  out  1  dirty flag.
- bist_valid_i  in  1  tag-store BIST done pulse.
- bist_res_i  in  SetAssociativity  per-way BIST fail bits.
- bist_res_o  out  SetAssociativity  latched BIST result.
- bist_done_o  out  1  BIST complete; the arbiter is in RUN.
- perf_lkp_cnt_o  out  32  granted lookups (optional feature).
- perf_fl_cnt_o  out  32  granted flushes (optional feature).

Behaviour:
- Clocking and reset:
  - All state is clocked on clk_i and reset asynchronously by rst_ni=0.
  - Reset values: req_valid_o=0, req_* payload=0, lkp_ready_o=0, fl_ready_o=0, bist_res_o=0, bist_done_o=0, perf counters=0, FSM=BIST_REQ, starve counter=0.
- FSM states:
  - BIST_REQ: load the output register with mode=Bist and all other payload 0, then go to BIST_ISSUE the next cycle.
  - BIST_ISSUE: go to BIST_WAIT on the cycle where req_valid_o & req_ready_i.
  - BIST_WAIT: req_valid_o=0. On bist_valid_i, latch bist_res_i into bist_res_o and go to RUN.
  - RUN: bist_done_o=1. This state is terminal until reset.
  - lkp_ready_o and fl_ready_o stay 0 in every state except RUN.
- Output stage:
  - One register slot.
  - The slot can load when it is empty, or when it is full and req_ready_i=1 in the same cycle (back-to-back issue, one request per cycle).
  - The payload must stay stable while req_valid_o=1 and req_ready_i=0.
  - Latency is 1 cycle from input handshake to req_valid_o.
- Arbitration (RUN, slot can load):
  - Flush wins if fl_valid_i=1 and the starve counter < MaxStarve.
  - Otherwise lookup wins if lkp_valid_i=1.
  - Otherwise flush wins if fl_valid_i=1.
  - At most one of lkp_ready_o / fl_ready_o is high per cycle. Each ready is asserted only for the granted requester; it is combinational from valid and the slot state.
- Starve counter:
  - Increments, saturating at MaxStarve, when flush is granted while lkp_valid_i=1.
  - Clears to 0 on any lookup grant, or on any cycle with lkp_valid_i=0.
- Lookup payload:
  - mode=Lookup, ind = ~spm_lock_i & ~flushed_i (sampled at grant), index, tag and dirty taken from the inputs.
  - If the computed ind is all-zero, the lookup is still accepted but dropped: it is not loaded into the slot and no request is issued.
- Flush payload:
  - mode=Flush, ind=fl_way_i, index=fl_index_i, tag=0, dirty=0.
  - A flush with fl_way_i not one-hot is a protocol error. It is caught by assertion only; the RTL forwards it unchanged.
- Assertions: bist_valid_i=1 outside BIST_WAIT is ignored and must not change bist_res_o.
- Reset mid-operation: any in-flight slot content is discarded and the FSM restarts at BIST_REQ.

Optional Feature:
- Macro: AXI_LLC_TAG_ARB_PERF_EN.
- Defined:
  - perf_lkp_cnt_o increments by 1 for each lookup loaded into the slot, including dropped all-zero-indicator lookups.
  - perf_fl_cnt_o increments by 1 for each flush loaded into the slot.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: no counter flops are built; both ports are tied to 0.

Test Plan:
- Bist sequencing:
  - Stimulus: release reset, req_ready_i=1, pulse bist_valid_i with bist_res_i=8'h04 five cycles later.
  - Required: exactly one req with mode=Bist; bist_res_o=8'h04 and bist_done_o=1 the cycle after the pulse; no lkp/fl ready before that.
- Lookup indicator:
  - Stimulus: spm_lock_i=8'h03, flushed_i=8'h10, lookup index=8'h2A, tag=20'hABCDE, dirty=1.
  - Required: next cycle req_ind_o=8'hEC, index 8'h2A, tag 20'hABCDE, dirty 1, mode=Lookup.
- Backpressure:
  - Stimulus: hold req_ready_i=0 for 6 cycles with lookup and flush both pending.
  - Required: payload stable, no further readies; after ready=1, one transfer per cycle with no bubble.
- Starvation:
  - Stimulus: fl_valid_i and lkp_valid_i held at 1 continuously, MaxStarve=4.
  - Required: grant pattern F,F,F,F,L repeating.
- Drop:
  - Stimulus: spm_lock_i|flushed_i=8'hFF, one lookup.
  - Required: lkp_ready_o=1 for one cycle, req_valid_o stays 0; with AXI_LLC_TAG_ARB_PERF_EN, perf_lkp_cnt_o=1.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 while a Flush is held with req_ready_i=0.
  - Required: req_valid_o=0 immediately; after release the first request is mode=Bist.
